// File: rtl/handle_translator.sv
// Handle-to-physical address translator with a one-entry last-handle cache; bypass/hit 1 cycle, miss 2 cycles.
// Response is held in RESP until rsp_ready; req_ready is high only in IDLE.
module handle_translator #(
    parameter int ADDR_WIDTH = 64,
    parameter int HNDL_WIDTH = 8
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   req_valid,
    output logic                                   req_ready,
    input  logic [ADDR_WIDTH-1:0]                  req_addr,
    output logic                                   rsp_valid,
    input  logic                                   rsp_ready,
    output logic [ADDR_WIDTH-1:0]                  rsp_addr,
    output logic                                   rsp_fault,
    output logic [HNDL_WIDTH-1:0]                  cell_cs,
    output logic                                   cell_read_address,
    input  logic [ADDR_WIDTH-HNDL_WIDTH-2:0]       cell_data,
    input  logic                                   inval_valid,
    input  logic [HNDL_WIDTH-1:0]                  inval_id
);
    localparam int M = ADDR_WIDTH - HNDL_WIDTH - 1;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_RESP} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_cache_v;
    logic [HNDL_WIDTH-1:0]   r_cache_id;
    logic [M-1:0]            r_cache_base;
    logic [HNDL_WIDTH-1:0]   r_id;
    logic [M-1:0]            r_off;
    logic [ADDR_WIDTH-1:0]   r_rsp_addr;
    logic                    r_rsp_fault;

    logic                    w_flag;
    logic [HNDL_WIDTH-1:0]   w_id;
    logic [M-1:0]            w_off;
    logic                    w_hit;
    logic                    w_accept;
    logic [M-1:0]            w_base_sel;
    logic [M-1:0]            w_off_sel;
    logic [M:0]              w_sum;
    logic [ADDR_WIDTH-1:0]   w_res_addr;

    assign w_flag   = req_addr[ADDR_WIDTH-1];
    assign w_id     = req_addr[ADDR_WIDTH-2:M];
    assign w_off    = req_addr[M-1:0];
    assign w_hit    = r_cache_v && (r_cache_id == w_id);
    assign w_accept = (r_state == S_IDLE) && req_valid;

    // One adder serves both the hit path (cache base) and the end of LOOKUP (cell bus base).
    assign w_base_sel = (r_state == S_LOOKUP) ? cell_data : r_cache_base;
    assign w_off_sel  = (r_state == S_LOOKUP) ? r_off     : w_off;
    assign w_sum      = {1'b0, w_base_sel} + {1'b0, w_off_sel};
    assign w_res_addr = w_sum[M] ? '0 : {{(HNDL_WIDTH+1){1'b0}}, w_sum[M-1:0]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next            = r_state;
        req_ready         = 1'b0;
        rsp_valid         = 1'b0;
        cell_cs           = '0;
        cell_read_address = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next = (w_flag && !w_hit) ? S_LOOKUP : S_RESP;
                end
            end
            S_LOOKUP: begin
                cell_cs           = r_id;
                cell_read_address = 1'b1;
                w_next            = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cache_v    <= 1'b0;
            r_cache_id   <= '0;
            r_cache_base <= '0;
            r_id         <= '0;
            r_off        <= '0;
            r_rsp_addr   <= '0;
            r_rsp_fault  <= 1'b0;
        end else begin
            if (w_accept) begin
                if (!w_flag) begin
                    r_rsp_addr  <= req_addr;
                    r_rsp_fault <= 1'b0;
                end else if (w_hit) begin
                    r_rsp_addr  <= w_res_addr;
                    r_rsp_fault <= w_sum[M];
                end else begin
                    r_id  <= w_id;
                    r_off <= w_off;
                end
            end
            // A same-cycle invalidate of the id being installed leaves the entry invalid.
            if (r_state == S_LOOKUP) begin
                r_rsp_addr   <= w_res_addr;
                r_rsp_fault  <= w_sum[M];
                r_cache_id   <= r_id;
                r_cache_base <= cell_data;
                r_cache_v    <= !(inval_valid && (inval_id == r_id));
            end else if (inval_valid && (inval_id == r_cache_id)) begin
                r_cache_v <= 1'b0;
            end
        end
    end

    assign rsp_addr  = r_rsp_addr;
    assign rsp_fault = r_rsp_fault;

endmodule

// File: tb/tb_handle_translator.sv
// Directed bench for handle_translator (W=16, H=3); a scoreboard queue feeds a negedge monitor.
module tb_handle_translator;
    localparam int W = 16;
    localparam int H = 3;
    localparam int M = W - H - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [W-1:0]  req_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_addr;
    logic          rsp_fault;
    logic [H-1:0]  cell_cs;
    logic          cell_read_address;
    logic [M-1:0]  cell_data;
    logic          inval_valid;
    logic [H-1:0]  inval_id;

    logic [M-1:0]  cell_base [8];
    logic [W:0]    sb_q [$];
    int            checks   = 0;
    int            failures = 0;

    handle_translator #(.ADDR_WIDTH(W), .HNDL_WIDTH(H)) dut (
        .clock             (clock),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_addr          (req_addr),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_addr          (rsp_addr),
        .rsp_fault         (rsp_fault),
        .cell_cs           (cell_cs),
        .cell_read_address (cell_read_address),
        .cell_data         (cell_data),
        .inval_valid       (inval_valid),
        .inval_id          (inval_id)
    );

    always #5 clock = ~clock;

    // Cell array: combinational read of the selected cell.
    always_comb begin
        cell_data = '0;
        if (cell_read_address) cell_data = cell_base[cell_cs];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                logic [W:0] e;
                e = sb_q.pop_front();
                chk("rsp_addr", 32'(rsp_addr), 32'(e[W-1:0]));
                chk("rsp_fault", 32'(rsp_fault), 32'(e[W]));
            end
        end
    end

    task automatic do_req(input logic [W-1:0] addr, input logic [W-1:0] exp_addr,
                          input logic exp_fault, input logic miss,
                          input logic inv_en, input logic [H-1:0] inv_id);
        @(posedge clock); #1;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        sb_q.push_back({exp_fault, exp_addr});
        @(posedge clock); #1;
        req_valid = 1'b0;
        if (miss) begin
            chk("lookup_rd", 32'(cell_read_address), 32'd1);
            chk("lookup_cs", 32'(cell_cs), 32'(addr[W-2:M]));
            chk("lookup_no_vld", 32'(rsp_valid), 32'd0);
            if (inv_en) begin
                inval_valid = 1'b1;
                inval_id    = inv_id;
            end
            @(posedge clock); #1;
            inval_valid = 1'b0;
        end
        chk("rsp_latency", 32'(rsp_valid), 32'd1);
        chk("resp_no_rd", 32'(cell_read_address), 32'd0);
        chk("resp_cs_zero", 32'(cell_cs), 32'd0);
        @(posedge clock); #1;
        chk("rsp_done", 32'(rsp_valid), 32'd0);
    endtask

    task automatic pulse_inval(input logic [H-1:0] id);
        @(posedge clock); #1;
        inval_valid = 1'b1;
        inval_id    = id;
        @(posedge clock); #1;
        inval_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) cell_base[i] = '0;
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_addr    = '0;
        rsp_ready   = 1'b1;
        inval_valid = 1'b0;
        inval_id    = '0;
        #12;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_addr", 32'(rsp_addr), 32'd0);
        chk("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        chk("rst_cell_rd", 32'(cell_read_address), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        chk("rst_req_ready", 32'(req_ready), 32'd1);

        do_req(16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 3'd0);
        cell_base[2] = 12'h300;
        do_req(16'hA010, 16'h0310, 1'b0, 1'b1, 1'b0, 3'd0);
        do_req(16'hA020, 16'h0320, 1'b0, 1'b0, 1'b0, 3'd0);
        cell_base[5] = 12'hFF0;
        do_req(16'hD020, 16'h0000, 1'b1, 1'b1, 1'b0, 3'd0);
        do_req(16'hD00F, 16'h0FFF, 1'b0, 1'b0, 1'b0, 3'd0);

        do_req(16'hA010, 16'h0310, 1'b0, 1'b1, 1'b0, 3'd0);
        pulse_inval(3'd2);
        cell_base[2] = 12'h500;
        do_req(16'hA010, 16'h0510, 1'b0, 1'b1, 1'b0, 3'd0);
        pulse_inval(3'd2);
        cell_base[2] = 12'h300;
        do_req(16'hA010, 16'h0310, 1'b0, 1'b1, 1'b0, 3'd0);
        pulse_inval(3'd3);
        cell_base[2] = 12'h500;
        do_req(16'hA010, 16'h0310, 1'b0, 1'b0, 1'b0, 3'd0);

        cell_base[3] = 12'h100;
        do_req(16'hB010, 16'h0110, 1'b0, 1'b1, 1'b1, 3'd3);
        do_req(16'hB020, 16'h0120, 1'b0, 1'b1, 1'b0, 3'd0);
        do_req(16'hA030, 16'h0530, 1'b0, 1'b1, 1'b1, 3'd6);
        do_req(16'hA040, 16'h0540, 1'b0, 1'b0, 1'b0, 3'd0);

        // Backpressure with an invalidate landing while the response is held.
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 16'hA050;
        sb_q.push_back({1'b0, 16'h0550});
        @(posedge clock); #1;
        req_valid   = 1'b0;
        inval_valid = 1'b1;
        inval_id    = 3'd2;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_addr", 32'(rsp_addr), 32'h0550);
            chk("bp_fault", 32'(rsp_fault), 32'd0);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            @(posedge clock); #1;
            inval_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        chk("bp_done", 32'(rsp_valid), 32'd0);
        chk("bp_req_ready_after", 32'(req_ready), 32'd1);

        // Reset in the middle of a LOOKUP aborts the transaction.
        @(posedge clock); #1;
        req_valid = 1'b1;
        req_addr  = 16'hB010;
        @(posedge clock); #1;
        req_valid = 1'b0;
        chk("abort_lookup_rd", 32'(cell_read_address), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_rsp_addr", 32'(rsp_addr), 32'd0);
        chk("abort_rsp_fault", 32'(rsp_fault), 32'd0);
        chk("abort_cell_rd", 32'(cell_read_address), 32'd0);
        chk("abort_cell_cs", 32'(cell_cs), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        do_req(16'hA010, 16'h0510, 1'b0, 1'b1, 1'b0, 3'd0);

        repeat (3) @(posedge clock);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
